fetch_prefetch_buffer: RTL

FETCH_PREFETCH_BUFFER -- requirements
Module: fetch_prefetch_buffer

---
 rtl/fetch_prefetch_buffer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer. Issues word-aligned fetch requests on a
// request/grant/rvalid memory port, keeps a small FIFO of returned
// instructions with their PCs, and handles redirects by discarding
// responses that belong to the abandoned stream.
module fetch_prefetch_buffer #(
    parameter int WORD_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en_i,
    input  logic [WORD_WIDTH-1:0] pc_start_addr_i,
    input  logic                  branch_i,
    input  logic [WORD_WIDTH-1:0] branch_addr_i,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [WORD_WIDTH-1:0] instr_o,
    output logic [WORD_WIDTH-1:0] pc_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(DEPTH + MAX_OUTSTANDING + 1) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] fetch_addr;
    logic [WORD_WIDTH-1:0] resp_pc;
    logic [WORD_WIDTH-1:0] held_addr;
    logic                  held;
    logic                  pend;
    logic [OW-1:0]         outstanding;
    logic [OW-1:0]         discard;
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [WORD_WIDTH-1:0] instr_mem [DEPTH];
    logic [WORD_WIDTH-1:0] pc_mem    [DEPTH];

    logic [SW-1:0]         credit;
    logic                  can_issue;
    logic                  granted;
    logic                  resp;
    logic                  do_branch;
    logic                  push;
    logic                  pop;
    logic [OW-1:0]         out_next;
    logic [WORD_WIDTH-1:0] branch_target;
    logic [WORD_WIDTH-1:0] start_addr;

    // Live entries: buffered plus in flight, excluding responses already
    // marked for discard. A new request is only issued while a slot is free,
    // so every live response is guaranteed room in the FIFO.
    assign credit    = SW'(count) + SW'(outstanding) - SW'(discard);
    assign can_issue = fetch_en_i && (outstanding < OW'(MAX_OUTSTANDING))
                       && (credit < SW'(DEPTH));

    // An ungranted request stays up with its original address, even across
    // fetch_en_i drops and redirects.
    assign instr_req_o  = (state == RUN) && (held || can_issue);
    assign instr_addr_o = held ? held_addr : fetch_addr;

    assign granted   = instr_req_o && instr_gnt_i;
    assign resp      = (state == RUN) && instr_rvalid_i;
    assign do_branch = (state == RUN) && branch_i;
    assign push      = resp && !do_branch && (discard == '0);
    assign valid_o   = (count != '0);
    assign pop       = valid_o && ready_i && !do_branch;
    assign instr_o   = valid_o ? instr_mem[rd_ptr] : '0;
    assign pc_o      = valid_o ? pc_mem[rd_ptr] : '0;

    assign out_next      = outstanding + OW'(granted) - OW'(resp && (outstanding != '0));
    assign branch_target = branch_addr_i & ~WORD_WIDTH'(3);
    assign start_addr    = pc_start_addr_i & ~WORD_WIDTH'(3);

    // Control state: FSM, request tracking, discard accounting, FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_addr  <= '0;
            resp_pc     <= '0;
            held_addr   <= '0;
            held        <= 1'b0;
            pend        <= 1'b0;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en_i) begin
                        state      <= RUN;
                        fetch_addr <= start_addr;
                        resp_pc    <= start_addr;
                    end
                end
                RUN: begin
                    outstanding <= out_next;
                    held        <= instr_req_o && !instr_gnt_i;
                    if (instr_req_o && !instr_gnt_i) begin
                        held_addr <= instr_addr_o;
                    end
                    if (do_branch) begin
                        // Everything still in flight, including a grant
                        // taken this cycle, belongs to the old stream.
                        discard    <= out_next;
                        pend       <= instr_req_o && !instr_gnt_i;
                        fetch_addr <= branch_target;
                        resp_pc    <= branch_target;
                        count      <= '0;
                        rd_ptr     <= '0;
                        wr_ptr     <= '0;
                    end else begin
                        discard <= discard - OW'(resp && (discard != '0))
                                   + OW'(granted && pend);
                        if (granted) begin
                            pend <= 1'b0;
                        end
                        // A stale held request must not advance the
                        // already-redirected fetch address.
                        if (granted && !pend) begin
                            fetch_addr <= fetch_addr + WORD_WIDTH'(4);
                        end
                        if (push) begin
                            resp_pc <= resp_pc + WORD_WIDTH'(4);
                        end
                        count  <= count + CW'(push) - CW'(pop);
                        wr_ptr <= wr_ptr + PW'(push);
                        rd_ptr <= rd_ptr + PW'(pop);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO storage: instruction and its PC written at the tail on push.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= instr_rdata_i;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end

endmodule
